// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch/branch-prediction slice.
//   - RV32 opcode and funct3 codes for the control-transfer instructions
//   - 2-bit saturating branch counter encodings
//   - default fetch reset vector
package cpu_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BLT = 3'b100;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer storage.
//   clk, rstn             : clock, asynchronous active-low reset
//   rd_idx -> rd_*        : combinational fetch-side read of one entry
//   up_idx -> up_*        : combinational read of the entry being resolved
//   wr_en, wr_*           : write of entry up_idx at the clock edge (sets valid)
//   inv_en                : clear valid of entry up_idx at the clock edge
// Reads always return the pre-edge contents; a write becomes visible the
// cycle after it is issued.
module btb_array
    import cpu_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_target,
    output logic [1:0]       rd_ctr,
    input  logic [IDX_W-1:0] up_idx,
    output logic             up_valid,
    output logic [TAG_W-1:0] up_tag,
    output logic [31:0]      up_target,
    output logic [1:0]       up_ctr,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target,
    input  logic [1:0]       wr_ctr,
    input  logic             inv_en
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam logic [1:0] CTR_RST = CTR_WNT;

    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0][31:0]      target_q, target_d;

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_ctr    = ctr_q[rd_idx];

    assign up_valid  = valid_q[up_idx];
    assign up_tag    = tag_q[up_idx];
    assign up_target = target_q[up_idx];
    assign up_ctr    = ctr_q[up_idx];

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            valid_d[up_idx]  = 1'b1;
            ctr_d[up_idx]    = wr_ctr;
            tag_d[up_idx]    = wr_tag;
            target_d[up_idx] = wr_target;
        end else if (inv_en) begin
            valid_d[up_idx] = 1'b0;
        end
    end

    // Only valid and counter state carry reset values; tag/target are
    // don't-care while the entry is invalid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{CTR_RST}};
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch PC register with BTB-based next-PC prediction and EX-stage resolution.
//   clk, rstn              : clock, asynchronous active-low reset
//   stall                  : hold fetch PC (ignored on a redirect)
//   pc                     : registered fetch PC
//   pred_taken/pred_target : prediction for pc (pc+4 when not taken)
//   ex_*                   : resolved branch information from the EX stage
//   flush                  : combinational mispredict indication, kills IF/ID, ID/EX
//   br_cnt, miss_cnt       : wrapping counts of resolved branches / mispredicts
module branch_predict_unit
    import cpu_pkg::*;
#(
    parameter int          IDX_W    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        flush,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) return (ctr == CTR_ST)  ? CTR_ST  : ctr + 2'd1;
        else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    logic             f_valid, e_valid;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic [31:0]      f_target, e_target;
    logic [1:0]       f_ctr, e_ctr;

    logic             f_hit, e_hit, ex_br, mp;
    logic [31:0]      correct_pc;
    logic             wr_en, inv_en;
    logic [31:0]      wr_target;
    logic [1:0]       wr_ctr;

    btb_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
        .clk       (clk),
        .rstn      (rstn),
        .rd_idx    (pc_q[IDX_W+1:2]),
        .rd_valid  (f_valid),
        .rd_tag    (f_tag),
        .rd_target (f_target),
        .rd_ctr    (f_ctr),
        .up_idx    (ex_pc[IDX_W+1:2]),
        .up_valid  (e_valid),
        .up_tag    (e_tag),
        .up_target (e_target),
        .up_ctr    (e_ctr),
        .wr_en     (wr_en),
        .wr_tag    (ex_pc[31:IDX_W+2]),
        .wr_target (wr_target),
        .wr_ctr    (wr_ctr),
        .inv_en    (inv_en)
    );

    // Fetch-side prediction
    assign f_hit       = f_valid && (f_tag == pc_q[31:IDX_W+2]);
    assign pred_taken  = f_hit && f_ctr[1];
    assign pred_target = pred_taken ? f_target : pc_q + 32'd4;

    // EX-side resolution. A non-branch that was predicted taken means the
    // BTB entry aliased onto a different instruction.
    assign ex_br = ex_valid && ex_is_branch;
    assign e_hit = e_valid && (e_tag == ex_pc[31:IDX_W+2]);

    always_comb begin
        mp = 1'b0;
        if (ex_br && (ex_taken != ex_pred_taken))
            mp = 1'b1;
        if (ex_br && ex_taken && ex_pred_taken && (ex_target != ex_pred_target))
            mp = 1'b1;
        if (ex_valid && !ex_is_branch && ex_pred_taken)
            mp = 1'b1;
    end

    assign flush      = mp;
    assign correct_pc = (ex_taken && ex_is_branch) ? ex_target : ex_pc + 32'd4;

    always_comb begin
        wr_en     = 1'b0;
        inv_en    = 1'b0;
        wr_target = e_target;
        wr_ctr    = CTR_WT;
        if (ex_br) begin
            if (e_hit) begin
                wr_en  = 1'b1;
                wr_ctr = ctr_step(e_ctr, ex_taken);
                if (ex_taken) wr_target = ex_target;
            end else if (ex_taken) begin
                wr_en     = 1'b1;
                wr_ctr    = CTR_WT;
                wr_target = ex_target;
            end
        end else if (ex_valid && ex_pred_taken && e_hit) begin
            inv_en = 1'b1;
        end
    end

    // Redirect beats stall; stall beats prediction.
    always_comb begin
        if (mp)         pc_d = correct_pc;
        else if (stall) pc_d = pc_q;
        else            pc_d = pred_target;
        br_cnt_d   = br_cnt_q + {31'd0, ex_br};
        miss_cnt_d = miss_cnt_q + {31'd0, mp};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q       <= RESET_PC;
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign pc       = pc_q;
    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule
